// File: rtl/freq_meter_ctrl_if.sv
// freq_meter_ctrl_if: control and status bundle between the gate sequencer and its host/counter/latch
interface freq_meter_ctrl_if;
  logic start;
  logic stop;
  logic continuous;
  logic cnt_ovf;
  logic cnt_enable;
  logic cnt_clear_n;
  logic lat_lock;
  logic busy;
  logic done;
  logic over_range;
  modport master (output start, stop, continuous, cnt_ovf,
                  input  cnt_enable, cnt_clear_n, lat_lock, busy, done, over_range);
  modport slave  (input  start, stop, continuous, cnt_ovf,
                  output cnt_enable, cnt_clear_n, lat_lock, busy, done, over_range);
endinterface

// File: rtl/freq_meter_ctrl.sv
// freq_meter_ctrl: gate-timing sequencer (GATE -> SETTLE -> LOAD -> CLEAR) driving a BCD counter and display latch
module freq_meter_ctrl #(
  parameter int TIMER_W       = 24,
  parameter int GATE_CYCLES   = 1000,
  parameter int SETTLE_CYCLES = 2,
  parameter int LOAD_CYCLES   = 2,
  parameter int CLEAR_CYCLES  = 2
) (
  input logic clk,
  input logic reset,
  freq_meter_ctrl_if.slave f
);
  typedef enum logic [2:0] {IDLE, GATE, SETTLE, LOAD, CLEAR} state_t;
  state_t state, state_n;
  logic [TIMER_W-1:0] timer, timer_n, len;
  logic [1:0] ovf_sync;
  logic ovf_d, ovf_rise, stop_pend, ovf_seen, t0, enter;
  always_comb begin
    t0 = timer == '0;
    state_n = state;
    case (state)
      IDLE:    state_n = (f.start && !f.stop) ? GATE : IDLE;
      GATE:    state_n = f.stop ? CLEAR : t0 ? SETTLE : GATE;
      SETTLE:  state_n = t0 ? LOAD : SETTLE;
      LOAD:    state_n = t0 ? CLEAR : LOAD;
      CLEAR:   state_n = !t0 ? CLEAR : (f.continuous && !stop_pend && !f.stop) ? GATE : IDLE;
      default: state_n = IDLE;
    endcase
    len = state_n == GATE   ? TIMER_W'(GATE_CYCLES - 1) :
          state_n == SETTLE ? TIMER_W'(SETTLE_CYCLES - 1) :
          state_n == LOAD   ? TIMER_W'(LOAD_CYCLES - 1) :
          state_n == CLEAR  ? TIMER_W'(CLEAR_CYCLES - 1) : '0;
    enter = state_n != state;
    timer_n = enter ? len : t0 ? '0 : timer - 1'b1;
    ovf_rise = ovf_sync[1] && !ovf_d;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      timer         <= '0;
      ovf_sync      <= '0;
      ovf_d         <= 1'b0;
      stop_pend     <= 1'b0;
      ovf_seen      <= 1'b0;
      f.cnt_enable  <= 1'b0;
      f.cnt_clear_n <= 1'b0;
      f.lat_lock    <= 1'b1;
      f.busy        <= 1'b0;
      f.done        <= 1'b0;
      f.over_range  <= 1'b0;
    end else begin
      state    <= state_n;
      timer    <= timer_n;
      ovf_sync <= {ovf_sync[0], f.cnt_ovf};
      ovf_d    <= ovf_sync[1];
      // a stop seen anywhere while busy forces the next exit to IDLE
      if (state_n == IDLE) stop_pend <= 1'b0;
      else if (f.stop && state != IDLE) stop_pend <= 1'b1;
      if (enter && state_n == GATE) ovf_seen <= 1'b0;
      else if (ovf_rise && (state == GATE || state == SETTLE)) ovf_seen <= 1'b1;
      f.cnt_enable  <= state_n == GATE;
      f.cnt_clear_n <= !(state_n == IDLE || state_n == CLEAR);
      f.lat_lock    <= state_n != LOAD;
      f.busy        <= state_n != IDLE;
      f.done        <= state == LOAD && state_n == CLEAR;
      if (state == LOAD && state_n == CLEAR) f.over_range <= ovf_seen;
    end
  end
endmodule

// File: tb/tb_freq_meter_ctrl.sv
// tb_freq_meter_ctrl: table-driven and directed checks of the gate sequencer with GATE=8, SETTLE/LOAD/CLEAR=2
module tb_freq_meter_ctrl;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int errors = 0;
  freq_meter_ctrl_if f ();
  freq_meter_ctrl #(.TIMER_W(24), .GATE_CYCLES(8), .SETTLE_CYCLES(2), .LOAD_CYCLES(2), .CLEAR_CYCLES(2))
    dut (.clk(clk), .reset(reset), .f(f.slave));
  always #5 clk = ~clk;
  typedef struct {
    logic st, sp, co, ov;
    logic [5:0] exp;
  } vec_t;
  vec_t tbl[$];
  function automatic logic [5:0] outs();
    return {f.cnt_enable, f.cnt_clear_n, f.lat_lock, f.busy, f.done, f.over_range};
  endfunction
  task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic add(input logic st, input logic sp, input logic [5:0] exp);
    vec_t v;
    v.st = st; v.sp = sp; v.co = 1'b0; v.ov = 1'b0; v.exp = exp;
    tbl.push_back(v);
  endtask
  task automatic drive(input logic st, input logic sp, input logic co, input logic ov);
    f.start = st; f.stop = sp; f.continuous = co; f.cnt_ovf = ov;
  endtask
  task automatic start_run(input logic co);
    drive(1'b1, 1'b0, co, 1'b0);
    step();
    f.start = 1'b0;
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end
  initial begin
    // {enable, clear_n, lock, busy, done, over_range}
    add(1, 1, 6'b001000);
    add(1, 0, 6'b111100);
    for (int i = 1; i < 8; i++) add(i == 3, 0, 6'b111100);
    add(0, 0, 6'b011100); add(0, 0, 6'b011100);
    add(0, 0, 6'b010100); add(0, 0, 6'b010100);
    add(0, 0, 6'b001110); add(0, 0, 6'b001100);
    add(0, 0, 6'b001000); add(0, 0, 6'b001000);
    drive(0, 0, 0, 0);
    #12;
    chk("reset_outputs", {2'b0, outs()}, 8'b00_001000);
    reset = 1'b0;
    step();
    chk("idle_after_reset", {2'b0, outs()}, 8'b00_001000);
    foreach (tbl[i]) begin
      drive(tbl[i].st, tbl[i].sp, tbl[i].co, tbl[i].ov);
      step();
      chk($sformatf("single_shot[%0d]", i), {2'b0, outs()}, {2'b0, tbl[i].exp});
    end
    start_run(1'b1);
    for (int k = 0; k < 28; k++) begin
      chk($sformatf("cont_done[%0d]", k), {7'b0, f.done}, {7'b0, k == 12 || k == 26});
      chk($sformatf("cont_en[%0d]", k), {7'b0, f.cnt_enable}, {7'b0, (k % 14) < 8});
      step();
    end
    f.stop = 1'b1;
    step();
    f.stop = 1'b0;
    for (int k = 0; k < 20 && f.busy; k++) step();
    chk("cont_stop_idle", {7'b0, f.busy}, 8'd0);
    start_run(1'b1);
    for (int k = 0; k < 3; k++) step();
    chk("gate4_enable", {7'b0, f.cnt_enable}, 8'd1);
    f.stop = 1'b1;
    step();
    f.stop = 1'b0;
    chk("abort_clear1", {2'b0, outs()}, 8'b00_001100);
    step();
    chk("abort_clear2", {2'b0, outs()}, 8'b00_001100);
    step();
    chk("abort_idle", {2'b0, outs()}, 8'b00_001000);
    step();
    chk("abort_stays_idle", {7'b0, f.busy}, 8'd0);
    start_run(1'b1);
    for (int k = 0; k < 10; k++) step();
    chk("load_lock1", {7'b0, f.lat_lock}, 8'd0);
    f.stop = 1'b1;
    step();
    f.stop = 1'b0;
    chk("load_lock2", {7'b0, f.lat_lock}, 8'd0);
    step();
    chk("load_stop_done", {2'b0, outs()}, 8'b00_001110);
    step();
    step();
    chk("load_stop_idle", {2'b0, outs()}, 8'b00_001000);
    f.continuous = 1'b0;
    start_run(1'b0);
    step();
    step();
    f.cnt_ovf = 1'b1;
    step();
    f.cnt_ovf = 1'b0;
    for (int k = 3; k < 12; k++) step();
    chk("ovf_done", {2'b0, outs()}, 8'b00_001111);
    for (int k = 0; k < 3; k++) step();
    start_run(1'b0);
    for (int k = 0; k < 11; k++) step();
    chk("ovf_held", {7'b0, f.over_range}, 8'd1);
    step();
    chk("clean_done", {2'b0, outs()}, 8'b00_001110);
    for (int k = 0; k < 3; k++) step();
    start_run(1'b1);
    for (int k = 0; k < 8; k++) step();
    chk("in_settle", {2'b0, outs()}, 8'b00_011100);
    #2 reset = 1'b1;
    #1;
    chk("async_reset", {2'b0, outs()}, 8'b00_001000);
    #2 reset = 1'b0;
    drive(1, 1, 1, 0);
    step();
    chk("start_stop_idle", {2'b0, outs()}, 8'b00_001000);
    drive(0, 0, 0, 0);
    step();
    chk("still_idle", {7'b0, f.busy}, 8'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
